// File: rtl/lcd_spi_display_receiver.sv
// lcd_spi_display_receiver: ILI9341-style 4-wire SPI command/data decoder emitting addressed RGB565 pixel writes
module lcd_spi_display_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 240,
    parameter int HEIGHT      = 320
) (
    input  logic        i_clk_100MHz,
    input  logic        i_rst_n,
    input  logic        i_cs,
    input  logic        i_dcrs,
    input  logic        i_sdi,
    input  logic        i_sck,
    output logic        o_cmd_valid,
    output logic [7:0]  o_cmd,
    output logic        o_pix_valid,
    output logic [8:0]  o_pix_x,
    output logic [8:0]  o_pix_y,
    output logic [15:0] o_pix_data,
    output logic        o_frame_start,
    output logic        o_disp_on,
    output logic        o_sleep_out,
    output logic        o_err
);
    localparam logic [15:0] W_LIM = 16'(WIDTH);
    localparam logic [15:0] H_LIM = 16'(HEIGHT);
    localparam logic [8:0]  W_END = 9'(WIDTH - 1);
    localparam logic [8:0]  H_END = 9'(HEIGHT - 1);

    typedef enum logic [2:0] {IDLE, CASET, PASET, SKIP, RAMWR} state_t;

    state_t state, state_d;
    logic [SYNC_STAGES-1:0] cs_sr, dc_sr, sdi_sr, sck_sr;
    logic cs_s, dc_s, sdi_s, sck_s, sck_q, armed, rise;
    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic byte_stb, byte_dc;
    logic [7:0] rx_byte, p0, p1, p2, hi;
    logic [1:0] pcnt;
    logic half;
    logic [8:0] sc, ec, sp, ep, x, y;
    logic [15:0] p_start, p_end;
    logic cmd_stb, par_stb, pix_stb, win_ok, win_bad;

    assign cs_s  = cs_sr[SYNC_STAGES-1];
    assign dc_s  = dc_sr[SYNC_STAGES-1];
    assign sdi_s = sdi_sr[SYNC_STAGES-1];
    assign sck_s = sck_sr[SYNC_STAGES-1];
    // armed only after cs is seen high, so a byte cut by reset is never resumed
    assign rise  = sck_s & ~sck_q & ~cs_s & armed;

    always_ff @(posedge i_clk_100MHz or negedge i_rst_n)
        if (!i_rst_n) begin
            cs_sr  <= '0;
            dc_sr  <= '0;
            sdi_sr <= '0;
            sck_sr <= '0;
            sck_q  <= 1'b0;
            armed  <= 1'b0;
        end else begin
            cs_sr  <= {cs_sr[SYNC_STAGES-2:0], i_cs};
            dc_sr  <= {dc_sr[SYNC_STAGES-2:0], i_dcrs};
            sdi_sr <= {sdi_sr[SYNC_STAGES-2:0], i_sdi};
            sck_sr <= {sck_sr[SYNC_STAGES-2:0], i_sck};
            sck_q  <= sck_s;
            armed  <= armed | cs_s;
        end

    always_ff @(posedge i_clk_100MHz or negedge i_rst_n)
        if (!i_rst_n) begin
            bit_cnt  <= 3'd0;
            shreg    <= 7'd0;
            byte_stb <= 1'b0;
            byte_dc  <= 1'b0;
            rx_byte  <= 8'd0;
        end else begin
            byte_stb <= rise && bit_cnt == 3'd7;
            if (cs_s || !armed)
                bit_cnt <= 3'd0;
            else if (rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                shreg   <= {shreg[5:0], sdi_s};
                if (bit_cnt == 3'd7) begin
                    rx_byte <= {shreg, sdi_s};
                    byte_dc <= dc_s;
                end
            end
        end

    assign p_start = {p0, p1};
    assign p_end   = {p2, rx_byte};

    always_comb begin
        state_d = state;
        cmd_stb = byte_stb & ~byte_dc;
        par_stb = byte_stb & byte_dc & (state == CASET || state == PASET);
        pix_stb = byte_stb & byte_dc & (state == RAMWR) & half;
        win_ok  = 1'b0;
        win_bad = 1'b0;
        if (cmd_stb)
            state_d = rx_byte == 8'h2A ? CASET : rx_byte == 8'h2B ? PASET : rx_byte == 8'h2C ? RAMWR : SKIP;
        else if (par_stb && pcnt == 2'd3) begin
            state_d = SKIP;
            win_ok  = p_start <= p_end && p_end < (state == CASET ? W_LIM : H_LIM);
            win_bad = !win_ok;
        end
    end

    always_ff @(posedge i_clk_100MHz or negedge i_rst_n)
        if (!i_rst_n)
            state <= IDLE;
        else
            state <= state_d;

    always_ff @(posedge i_clk_100MHz or negedge i_rst_n)
        if (!i_rst_n) begin
            o_cmd_valid   <= 1'b0;
            o_cmd         <= 8'd0;
            o_pix_valid   <= 1'b0;
            o_pix_x       <= 9'd0;
            o_pix_y       <= 9'd0;
            o_pix_data    <= 16'd0;
            o_frame_start <= 1'b0;
            o_disp_on     <= 1'b0;
            o_sleep_out   <= 1'b0;
            o_err         <= 1'b0;
            pcnt          <= 2'd0;
            p0            <= 8'd0;
            p1            <= 8'd0;
            p2            <= 8'd0;
            hi            <= 8'd0;
            half          <= 1'b0;
            sc            <= 9'd0;
            ec            <= W_END;
            sp            <= 9'd0;
            ep            <= H_END;
            x             <= 9'd0;
            y             <= 9'd0;
        end else begin
            o_cmd_valid   <= cmd_stb;
            o_frame_start <= cmd_stb && rx_byte == 8'h2C;
            o_pix_valid   <= pix_stb;
            o_err         <= win_bad;
            if (cmd_stb) begin
                o_cmd <= rx_byte;
                pcnt  <= 2'd0;
                half  <= 1'b0;
                if (rx_byte == 8'h11) o_sleep_out <= 1'b1;
                if (rx_byte == 8'h10) o_sleep_out <= 1'b0;
                if (rx_byte == 8'h29) o_disp_on <= 1'b1;
                if (rx_byte == 8'h28) o_disp_on <= 1'b0;
                if (rx_byte == 8'h2C) begin
                    x <= sc;
                    y <= sp;
                end
            end
            if (par_stb) begin
                pcnt <= pcnt + 2'd1;
                if (pcnt == 2'd0) p0 <= rx_byte;
                if (pcnt == 2'd1) p1 <= rx_byte;
                if (pcnt == 2'd2) p2 <= rx_byte;
            end
            if (win_ok && state == CASET) begin
                sc <= p_start[8:0];
                ec <= p_end[8:0];
            end
            if (win_ok && state == PASET) begin
                sp <= p_start[8:0];
                ep <= p_end[8:0];
            end
            if (byte_stb && byte_dc && state == RAMWR) begin
                half <= ~half;
                hi   <= half ? hi : rx_byte;
            end
            if (pix_stb) begin
                o_pix_data <= {hi, rx_byte};
                o_pix_x    <= x;
                o_pix_y    <= y;
                x          <= x == ec ? sc : x + 9'd1;
                if (x == ec) y <= y == ep ? sp : y + 9'd1;
            end
        end
endmodule

// File: tb/tb_lcd_spi_display_receiver.sv
// tb_lcd_spi_display_receiver: randomized SPI traffic checked against a byte-level display model
`timescale 1ns/1ps
module tb_lcd_spi_display_receiver;
    localparam int S = 2;
    localparam int W = 240;
    localparam int H = 320;

    logic clk = 1'b0, rst_n = 1'b0, cs = 1'b1, dcrs = 1'b0, sdi = 1'b0, sck = 1'b0;
    logic o_cmd_valid, o_pix_valid, o_frame_start, o_disp_on, o_sleep_out, o_err;
    logic [7:0] o_cmd;
    logic [8:0] o_pix_x, o_pix_y;
    logic [15:0] o_pix_data;

    lcd_spi_display_receiver #(.SYNC_STAGES(S), .WIDTH(W), .HEIGHT(H)) dut (
        .i_clk_100MHz(clk), .i_rst_n(rst_n), .i_cs(cs), .i_dcrs(dcrs), .i_sdi(sdi), .i_sck(sck),
        .o_cmd_valid(o_cmd_valid), .o_cmd(o_cmd), .o_pix_valid(o_pix_valid), .o_pix_x(o_pix_x),
        .o_pix_y(o_pix_y), .o_pix_data(o_pix_data), .o_frame_start(o_frame_start),
        .o_disp_on(o_disp_on), .o_sleep_out(o_sleep_out), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_errors = 0;
    int cyc = 0, rise_cyc = 0, cmd_cyc = 0;
    int obs_err = 0, obs_frames = 0, both = 0;
    logic [7:0] obs_cmd[$], exp_cmd[$];
    logic [33:0] obs_pix[$], exp_pix[$];
    logic [7:0] cmd_tab [9] = '{8'h10, 8'h11, 8'h28, 8'h29, 8'h2A, 8'h2B, 8'h2C, 8'h00, 8'h36};

    int m_cmd, m_sc, m_ec, m_sp, m_ep, m_x, m_y, m_err, m_frames;
    bit m_disp, m_sleep, m_have_hi;
    logic [7:0] m_hi, m_last;
    logic [7:0] pq[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (rst_n) begin
        if (o_cmd_valid) begin
            obs_cmd.push_back(o_cmd);
            cmd_cyc = cyc;
        end
        if (o_pix_valid) obs_pix.push_back({o_pix_x, o_pix_y, o_pix_data});
        if (o_err) obs_err++;
        if (o_frame_start) obs_frames++;
        if (o_cmd_valid && o_pix_valid) both++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        m_cmd = -1; m_sc = 0; m_ec = W - 1; m_sp = 0; m_ep = H - 1; m_x = 0; m_y = 0;
        m_disp = 0; m_sleep = 0; m_have_hi = 0; m_hi = 0; m_last = 0;
        pq.delete();
    endtask

    task automatic model_byte(input bit dc, input logic [7:0] b);
        int s, e;
        if (!dc) begin
            exp_cmd.push_back(b);
            m_cmd = int'(b);
            m_last = b;
            pq.delete();
            m_have_hi = 0;
            if (b == 8'h11) m_sleep = 1;
            if (b == 8'h10) m_sleep = 0;
            if (b == 8'h29) m_disp = 1;
            if (b == 8'h28) m_disp = 0;
            if (b == 8'h2C) begin
                m_x = m_sc;
                m_y = m_sp;
                m_frames++;
            end
        end else if ((m_cmd == 'h2A || m_cmd == 'h2B) && pq.size() < 4) begin
            pq.push_back(b);
            if (pq.size() == 4) begin
                s = int'({pq[0], pq[1]});
                e = int'({pq[2], pq[3]});
                if (s <= e && e < (m_cmd == 'h2A ? W : H)) begin
                    if (m_cmd == 'h2A) begin m_sc = s; m_ec = e; end
                    else begin m_sp = s; m_ep = e; end
                end else
                    m_err++;
            end
        end else if (m_cmd == 'h2C) begin
            if (!m_have_hi) begin
                m_hi = b;
                m_have_hi = 1;
            end else begin
                exp_pix.push_back({9'(m_x), 9'(m_y), m_hi, b});
                m_have_hi = 0;
                m_x++;
                if (m_x > m_ec) begin
                    m_x = m_sc;
                    m_y++;
                    if (m_y > m_ep) m_y = m_sp;
                end
            end
        end
    endtask

    task automatic send_byte(input bit dc, input logic [7:0] b, input int nbits);
        cs = 1'b0;
        dcrs = dc;
        tick(2);
        for (int i = 7; i >= 8 - nbits; i--) begin
            sdi = b[i];
            tick(3);
            sck = 1'b1;
            if (i == 0) rise_cyc = cyc;
            tick(3);
            sck = 1'b0;
        end
        tick(2);
        if (nbits == 8 && $urandom_range(0, 1) == 1) begin
            cs = 1'b1;
            tick(3);
        end
    endtask

    task automatic send_cmd(input logic [7:0] b);
        send_byte(1'b0, b, 8);
        model_byte(1'b0, b);
    endtask

    task automatic send_dat(input logic [7:0] b);
        send_byte(1'b1, b, 8);
        model_byte(1'b1, b);
    endtask

    task automatic compare(input string tag);
        int n;
        tick(12);
        check({tag, " cmd count"}, 64'(obs_cmd.size()), 64'(exp_cmd.size()));
        n = obs_cmd.size() < exp_cmd.size() ? obs_cmd.size() : exp_cmd.size();
        for (int i = 0; i < n; i++) check({tag, " cmd"}, 64'(obs_cmd[i]), 64'(exp_cmd[i]));
        check({tag, " pix count"}, 64'(obs_pix.size()), 64'(exp_pix.size()));
        n = obs_pix.size() < exp_pix.size() ? obs_pix.size() : exp_pix.size();
        for (int i = 0; i < n; i++) check({tag, " pix"}, 64'(obs_pix[i]), 64'(exp_pix[i]));
        check({tag, " err"}, 64'(obs_err), 64'(m_err));
        check({tag, " frames"}, 64'(obs_frames), 64'(m_frames));
        check({tag, " disp"}, 64'(o_disp_on), 64'(m_disp));
        check({tag, " sleep"}, 64'(o_sleep_out), 64'(m_sleep));
        check({tag, " cmd held"}, 64'(o_cmd), 64'(m_last));
        obs_cmd.delete(); exp_cmd.delete(); obs_pix.delete(); exp_pix.delete();
    endtask

    task automatic rand_burst();
        logic [7:0] c;
        logic [7:0] pb [5];
        logic [15:0] s16, e16;
        int lim, s, e, n;
        c = cmd_tab[$urandom_range(0, 8)];
        send_cmd(c);
        if (c == 8'h2A || c == 8'h2B) begin
            lim = c == 8'h2A ? W : H;
            s = int'($urandom_range(0, lim - 1));
            e = $urandom_range(0, 4) == 0 ? s - 1 : s + int'($urandom_range(0, 3));
            s16 = 16'(s);
            e16 = 16'(e);
            pb[0] = s16[15:8]; pb[1] = s16[7:0]; pb[2] = e16[15:8]; pb[3] = e16[7:0];
            pb[4] = 8'($urandom);
            n = int'($urandom_range(3, 5));
            for (int i = 0; i < n; i++) send_dat(pb[i]);
        end else begin
            n = c == 8'h2C ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 2));
            for (int i = 0; i < n; i++) send_dat(8'($urandom));
        end
    endtask

    initial begin
        #3ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        m_err = 0;
        m_frames = 0;
        model_reset();
        tick(3);
        check("reset outputs", 64'({o_cmd_valid, o_cmd, o_pix_valid, o_pix_x, o_pix_y, o_pix_data,
                                    o_frame_start, o_disp_on, o_sleep_out, o_err}), 64'd0);
        rst_n = 1'b1;
        tick(4);

        send_cmd(8'h11);
        send_cmd(8'h29);
        check("latency", 64'(cmd_cyc - rise_cyc), 64'(S + 2));
        compare("sleep/disp");

        send_cmd(8'h2C);
        send_dat(8'hF8); send_dat(8'h00); send_dat(8'h07); send_dat(8'hE0);
        tick(12);
        check("pix0", 64'(obs_pix[0]), 64'({9'd0, 9'd0, 16'hF800}));
        check("pix1", 64'(obs_pix[1]), 64'({9'd1, 9'd0, 16'h07E0}));
        compare("ramwr");

        send_cmd(8'h2A);
        send_dat(8'h00); send_dat(8'hF0); send_dat(8'h00); send_dat(8'hF5);
        tick(12);
        check("caset reject", 64'(obs_err), 64'd1);
        send_cmd(8'h2C);
        for (int i = 0; i < W + 1; i++) begin
            send_dat(8'($urandom));
            send_dat(8'($urandom));
        end
        tick(12);
        check("full width wrap", 64'(obs_pix[W][33:16]), 64'({9'd0, 9'd1}));
        compare("full window");

        send_cmd(8'h2A);
        send_dat(8'h00); send_dat(8'h0A); send_dat(8'h00); send_dat(8'h0B);
        send_cmd(8'h2B);
        send_dat(8'h00); send_dat(8'h05); send_dat(8'h00); send_dat(8'h06);
        send_cmd(8'h2C);
        for (int i = 0; i < 10; i++) send_dat(8'($urandom));
        tick(12);
        check("win wrap", 64'(obs_pix[4][33:16]), 64'({9'd10, 9'd5}));
        compare("window");

        send_cmd(8'h2A);
        send_dat(8'h00); send_dat(8'h00); send_dat(8'h00); send_dat(8'hEF);
        send_cmd(8'h2B);
        send_dat(8'h00); send_dat(8'h00); send_dat(8'h01); send_dat(8'h3F);
        send_cmd(8'h2C);
        send_dat(8'hAB);
        send_cmd(8'h2C);
        send_dat(8'h12); send_dat(8'h34);
        tick(12);
        check("abort pix", 64'(obs_pix[0]), 64'({9'd0, 9'd0, 16'h1234}));
        compare("abort");

        send_byte(1'b0, 8'hFF, 5);
        cs = 1'b1;
        tick(6);
        send_cmd(8'h29);
        compare("partial cs");

        for (int it = 0; it < 30; it++) begin
            rand_burst();
            compare("rand");
        end

        send_cmd(8'h29);
        send_cmd(8'h2A);
        send_dat(8'h00); send_dat(8'h00); send_dat(8'h00); send_dat(8'h03);
        send_cmd(8'h2C);
        for (int i = 0; i < 6; i++) send_dat(8'($urandom));
        send_dat(8'h5A);
        compare("pre reset");
        send_byte(1'b1, 8'hC3, 3);
        rst_n = 1'b0;
        #1;
        check("rst disp", 64'(o_disp_on), 64'd0);
        check("rst outs", 64'({o_cmd, o_pix_x, o_pix_y, o_pix_data, o_sleep_out}), 64'd0);
        tick(3);
        rst_n = 1'b1;
        model_reset();
        send_byte(1'b1, 8'h3C, 5);
        cs = 1'b1;
        tick(6);
        compare("post reset");
        send_cmd(8'h2C);
        for (int i = 0; i < 10; i++) send_dat(8'($urandom));
        compare("reset window");

        check("exclusive", 64'(both), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/lcd_spi_display_receiver.md
Name: lcd_spi_display_receiver

Overview:
- Display-side end of the 4-wire LCD SPI link (cs, dc/rs, sdi, sck): an ILI9341-style command/data decoder in RTL.
- Deserialises bytes, tracks the column/page address window and emits addressed 16-bit pixel writes.
- Used as an on-FPGA display emulator and loopback checker for the LCD controller path; its pixel port feeds a framebuffer or scoreboard.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each SPI input before edge detection (min 2).
- WIDTH, 240, columns; reset/default end column = WIDTH-1.
- HEIGHT, 320, pages (rows); reset/default end page = HEIGHT-1.

Ports:
- i_clk_100MHz  input  1  system clock; all logic on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_cs  input  1  SPI chip select, active low.
- i_dcrs  input  1  0 = command byte, 1 = data/parameter byte.
- i_sdi  input  1  serial data, MSB first.
- i_sck  input  1  SPI clock, mode 0 (sample on rising edge).
- o_cmd_valid  output  1  one-cycle pulse: command byte received.
- o_cmd  output  8  last command byte; held between pulses.
- o_pix_valid  output  1  one-cycle pulse: pixel write.
- o_pix_x  output  9  column of the current pixel.
- o_pix_y  output  9  page of the current pixel.
- o_pix_data  output  16  RGB565 pixel, high byte first on the wire.
- o_frame_start  output  1  one-cycle pulse on each 0x2C command.
- o_disp_on  output  1  display-on flag.
- o_sleep_out  output  1  sleep-out flag.
- o_err  output  1  one-cycle pulse: rejected address window.

Behaviour:
- Reset: all outputs 0; window SC=0, EC=WIDTH-1, SP=0, EP=HEIGHT-1; decoder IDLE; bit count 0; pixel half-byte flag clear.
- Input path:
  - i_cs, i_dcrs, i_sdi and i_sck each pass through SYNC_STAGES flops.
  - A rising sck is detected when the synchronised sck is 1 and was 0 on the previous cycle.
  - Rising edges count only while synchronised cs = 0.
  - Source requirement: sck high ≥3 clk cycles, sck low ≥3 clk cycles, sdi/dcrs stable ≥2 clk cycles either side of sck rise.
- Bit assembly:
  - Shift sdi in MSB first.
  - On the 8th bit, raise an internal byte strobe and latch dcrs as sampled with that bit.
  - Synchronised cs rising clears the bit count and drops any partial byte.
  - Decoder state, window and pixel half-byte survive cs toggles; the controller may frame each byte separately.
- Byte strobe with dcrs = 0 (command):
  - o_cmd and o_cmd_valid update on the next clock.
  - Any partial parameter set is discarded; window registers stay unchanged.
  - Pixel half-byte flag clears.
  - Commands: 0x11 sets o_sleep_out; 0x10 clears it; 0x29 sets o_disp_on; 0x28 clears it.
  - 0x2A → CASET (expect 4 params); 0x2B → PASET (expect 4 params).
  - 0x2C → RAMWR: x←SC, y←SP; o_frame_start pulses with o_cmd_valid.
  - Any other command → SKIP; its params are ignored.
- CASET/PASET parameters:
  - Byte order: start hi, start lo, end hi, end lo; 16-bit values.
  - Commit on the 4th byte only.
  - CASET commits if start ≤ end < WIDTH; PASET commits if start ≤ end < HEIGHT.
  - If not, registers stay unchanged and o_err pulses.
  - After commit or reject the decoder goes to SKIP; extra params are ignored.
  - The committed window applies at the next 0x2C, not to an in-progress RAMWR.
- RAMWR data:
  - First byte is held as the high byte. The second byte completes the pixel.
  - On the next clock: o_pix_valid=1, o_pix_data={hi,lo}, o_pix_x/o_pix_y = current address.
  - Address then advances: x+1; if x==EC then x←SC and y+1; if also y==EP then y←SP (wrap to window start).
  - Stays in RAMWR until the next command byte.
- Data bytes arriving in IDLE or SKIP are ignored.
- Latency: pin sck rise carrying bit 8 → pulse output high exactly SYNC_STAGES+2 clk cycles later.
- At most one of o_pix_valid/o_cmd_valid per cycle, since bytes are ≥48 clk apart.
- Reset mid-byte or mid-RAMWR:
  - Asynchronous return to reset values.
  - First byte after reset is decoded only if it starts on a fresh cs-low/sck sequence.

Test Plan:
- Send 0x11 then 0x29 → o_cmd_valid twice, o_cmd 0x11 then 0x29; o_sleep_out=1, o_disp_on=1; no pixel pulses.
- Send 0x2C, then bytes F8,00,07,E0 → o_frame_start once; pixels (0,0)=F800 and (1,0)=07E0.
- Send CASET 00 0A 00 0B, PASET 00 05 00 06, 0x2C, 5 pixels → addresses (10,5),(11,5),(10,6),(11,6),(10,5).
- Send CASET 00 F0 00 F5 (end ≥ WIDTH) → o_err pulse; next RAMWR starts at (0,0) with full window.
- Send 0x2C, high byte AB, then command 0x2C, then 12,34 → no pixel from AB; pixel (0,0)=1234.
- Deassert cs after 5 bits, then send a full 0x29 → partial byte dropped; o_cmd=0x29.
- Assert i_rst_n=0 mid-RAMWR at (3,0) → outputs and window return to reset values; o_disp_on=0.
